// File: rtl/bm_map_pkg.sv
// Shared definitions for the destructible (soft-block) map controller.
// Grid geometry, pixel mapping, blast limits, state/direction enums,
// cell coordinate struct, flat-index helper and the reset block map.
package bm_map_pkg;

  localparam int COLS       = 12;
  localparam int ROWS       = 12;
  localparam int TILE_PX    = 40;
  localparam int ORIGIN_PX  = 20;
  localparam int MAX_RADIUS = 4;
  localparam int FLAME_HOLD = 30;

  localparam int CELLS  = ROWS * COLS;
  localparam int IDX_W  = $clog2(CELLS) + 1;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int HOLD_W = $clog2(FLAME_HOLD);

  typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CENTER, ST_RAY_N, ST_RAY_E, ST_RAY_S, ST_RAY_W, ST_DONE, ST_HOLD
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cell_t;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
  endfunction

  // Crates sit in columns 2, 6 and 10 of every odd row.
  function automatic logic [CELLS-1:0] gen_init_map();
    logic [CELLS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        m[r*COLS+c] = ((c % 4) == 2) && ((r % 2) == 1);
      end
    end
    return m;
  endfunction

  localparam logic [CELLS-1:0] INIT_MAP = gen_init_map();

endpackage

// File: rtl/pixel_to_cell.sv
// Combinational pixel -> grid cell conversion.
// Ports:
//   px_x_i, px_y_i : pixel coordinates (10 bit)
//   cell_o         : row/col of the tile containing the pixel (valid when in range)
//   in_range_o     : pixel lies inside the ROWS x COLS grid
module pixel_to_cell
  import bm_map_pkg::*;
(
  input  logic [9:0] px_x_i,
  input  logic [9:0] px_y_i,
  output cell_t      cell_o,
  output logic       in_range_o
);

  logic [9:0] off_x, off_y;
  logic [9:0] q_x, q_y;

  always_comb begin
    // Below-origin pixels wrap to huge offsets; in_range_o masks them.
    off_x      = px_x_i - 10'(ORIGIN_PX);
    off_y      = px_y_i - 10'(ORIGIN_PX);
    q_x        = off_x / 10'(TILE_PX);
    q_y        = off_y / 10'(TILE_PX);
    in_range_o = (px_x_i >= 10'(ORIGIN_PX)) && (px_y_i >= 10'(ORIGIN_PX)) &&
                 (q_x < 10'(COLS)) && (q_y < 10'(ROWS));
    cell_o.col = q_x[COL_W-1:0];
    cell_o.row = q_y[ROW_W-1:0];
  end

endmodule

// File: rtl/destructible_map_ctrl.sv
// Soft-block map owner and single-bomb blast resolver.
// Ports:
//   Frame_Clk, Reset       : clock, synchronous active-high reset
//   Blast_Req/X/Y/Radius   : blast request (sampled in IDLE only), bomb pixel, radius
//   Wall_Map               : hard walls, bit = row*COLS+col, static during a blast
//   Block_Map, Flame_Map   : live crates, cells burning
//   Busy, Done             : blast in progress, resolution-complete pulse
//   Destroyed_Count        : crates destroyed by the last blast
//
// state    | meaning
// IDLE     | waiting for Blast_Req
// CENTER   | ignite the centre cell
// RAY_N..W | walk one ray, one cell per cycle
// DONE     | rays resolved, Done pulse
// HOLD     | flame displayed for FLAME_HOLD cycles
module destructible_map_ctrl
  import bm_map_pkg::*;
(
  input  logic             Frame_Clk,
  input  logic             Reset,
  input  logic             Blast_Req,
  input  logic [9:0]       Blast_X,
  input  logic [9:0]       Blast_Y,
  input  logic [2:0]       Blast_Radius,
  input  logic [CELLS-1:0] Wall_Map,
  output logic [CELLS-1:0] Block_Map,
  output logic [CELLS-1:0] Flame_Map,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       Destroyed_Count
);

  state_e            state_q, state_d;
  cell_t             cell_q;
  logic [2:0]        radius_q, step_q, count_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CELLS-1:0]  block_q, flame_q;
  logic              rej_q;

  cell_t             px_cell;
  logic              px_in_range, px_wall, req_ok;
  logic [IDX_W-1:0]  px_idx, ctr_idx, tgt_idx;

  dir_e              ray_dir;
  logic [ROW_W:0]    trow, step_r;
  logic [COL_W:0]    tcol, step_c;
  logic              tgt_ok, tgt_wall, tgt_soft, ray_end;

  pixel_to_cell u_pix (
    .px_x_i     (Blast_X),
    .px_y_i     (Blast_Y),
    .cell_o     (px_cell),
    .in_range_o (px_in_range)
  );

  always_comb begin
    px_idx  = cell_idx(px_cell.row, px_cell.col);
    px_wall = px_in_range ? Wall_Map[px_idx] : 1'b0;
    req_ok  = px_in_range && !px_wall && (Blast_Radius != 3'd0) &&
              (Blast_Radius <= 3'(MAX_RADIUS));
    ctr_idx = cell_idx(cell_q.row, cell_q.col);
  end

  // Ray target: bounds are checked on row/col before forming the flat index,
  // so an east step off column COLS-1 never lands on the next row.
  always_comb begin
    ray_dir = DIR_N;
    case (state_q)
      ST_RAY_E: ray_dir = DIR_E;
      ST_RAY_S: ray_dir = DIR_S;
      ST_RAY_W: ray_dir = DIR_W;
      default:  ray_dir = DIR_N;
    endcase
    step_r = (ROW_W+1)'(step_q);
    step_c = (COL_W+1)'(step_q);
    trow   = {1'b0, cell_q.row};
    tcol   = {1'b0, cell_q.col};
    tgt_ok = 1'b0;
    case (ray_dir)
      DIR_N: begin
        tgt_ok = step_r <= trow;
        trow   = trow - step_r;
      end
      DIR_E: begin
        tgt_ok = (tcol + step_c) <= (COL_W+1)'(COLS - 1);
        tcol   = tcol + step_c;
      end
      DIR_S: begin
        tgt_ok = (trow + step_r) <= (ROW_W+1)'(ROWS - 1);
        trow   = trow + step_r;
      end
      default: begin
        tgt_ok = step_c <= tcol;
        tcol   = tcol - step_c;
      end
    endcase
    tgt_idx  = cell_idx(trow[ROW_W-1:0], tcol[COL_W-1:0]);
    tgt_wall = tgt_ok && Wall_Map[tgt_idx];
    tgt_soft = tgt_ok && block_q[tgt_idx];
    ray_end  = !tgt_ok || tgt_wall || tgt_soft || (step_q == radius_q);
  end

  always_ff @(posedge Frame_Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Blast_Req && req_ok) state_d = ST_CENTER;
      ST_CENTER: state_d = ST_RAY_N;
      ST_RAY_N:  if (ray_end) state_d = ST_RAY_E;
      ST_RAY_E:  if (ray_end) state_d = ST_RAY_S;
      ST_RAY_S:  if (ray_end) state_d = ST_RAY_W;
      ST_RAY_W:  if (ray_end) state_d = ST_DONE;
      ST_DONE:   state_d = ST_HOLD;
      ST_HOLD:   if (hold_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy            = (state_q != ST_IDLE);
    Done            = (state_q == ST_DONE) || rej_q;
    Block_Map       = block_q;
    Flame_Map       = flame_q;
    Destroyed_Count = count_q;
  end

  always_ff @(posedge Frame_Clk) begin
    if (Reset) begin
      cell_q   <= '0;
      radius_q <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      block_q  <= INIT_MAP;
      flame_q  <= '0;
      count_q  <= '0;
      rej_q    <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Blast_Req) begin
            count_q <= '0;
            if (req_ok) begin
              cell_q   <= px_cell;
              radius_q <= Blast_Radius;
              step_q   <= 3'd1;
            end else begin
              rej_q <= 1'b1;
            end
          end
        end
        ST_CENTER: begin
          flame_q[ctr_idx] <= 1'b1;
          if (block_q[ctr_idx]) begin
            block_q[ctr_idx] <= 1'b0;
            count_q          <= count_q + 3'd1;
          end
        end
        ST_RAY_N, ST_RAY_E, ST_RAY_S, ST_RAY_W: begin
          if (tgt_ok && !tgt_wall) begin
            flame_q[tgt_idx] <= 1'b1;
            if (tgt_soft) begin
              block_q[tgt_idx] <= 1'b0;
              count_q          <= count_q + 3'd1;
            end
          end
          step_q <= ray_end ? 3'd1 : step_q + 3'd1;
        end
        ST_DONE: hold_q <= HOLD_W'(FLAME_HOLD - 1);
        ST_HOLD: begin
          // HOLD lasts exactly FLAME_HOLD cycles; flames drop on leaving it.
          hold_q <= hold_q - HOLD_W'(1);
          if (hold_q == '0) flame_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
